// File: rtl/seq_alu.sv
// Multi-cycle integer ALU: single-cycle add/sub/compare, iterative shift-add
// multiply and restoring divide, valid/ready on both sides.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             ze,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  acc, work, opnd;
  logic              neg;

  logic [2:0]        op;
  logic              is_float, is_signed, accept, last, busy;
  logic signed [WIDTH-1:0] a_sgn, b_sgn;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              lt, gt;

  logic [WIDTH-1:0]  quick_s;
  logic              quick_ze, quick_ill, go_mul, go_div;

  logic [WIDTH-1:0]  acc_nxt, work_nxt, opnd_nxt, iter_s;
  logic [WIDTH:0]    shifted, diff;

  logic              unused_instr;

  assign unused_instr = ^instruction[31:5];

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign op        = instruction[2:0];
  assign is_float  = instruction[3];
  assign is_signed = instruction[4];
  assign a_sgn     = a;
  assign b_sgn     = b;
  assign lt        = is_signed ? (a_sgn < b_sgn) : (a < b);
  assign gt        = is_signed ? (a_sgn > b_sgn) : (a > b);
  assign a_mag     = magnitude(a, is_signed);
  assign b_mag     = magnitude(b, is_signed);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == MUL) || (state == DIV);
  assign last      = (cnt == CW'(1));

  // Decode of the captured request; float requests never reach an opcode.
  always_comb begin
    quick_s   = '0;
    quick_ze  = 1'b0;
    quick_ill = 1'b0;
    go_mul    = 1'b0;
    go_div    = 1'b0;
    if (is_float) begin
      quick_ill = 1'b1;
    end else begin
      case (op)
        3'b000:  quick_s = a + b;
        3'b001:  quick_s = a - b;
        3'b011:  go_mul = 1'b1;
        3'b111:  if (b == '0) quick_ze = 1'b1; else go_div = 1'b1;
        3'b100:  quick_s = {{(WIDTH-1){1'b0}}, lt};
        3'b101:  quick_s = {{(WIDTH-1){1'b0}}, (a == b)};
        3'b110:  quick_s = {{(WIDTH-1){1'b0}}, gt};
        default: quick_ill = 1'b1;
      endcase
    end
  end

  // One iteration: acc is the product (MUL) or partial remainder (DIV);
  // work holds the multiplier or the dividend/quotient shift register.
  always_comb begin
    acc_nxt  = acc;
    work_nxt = work;
    opnd_nxt = opnd;
    shifted  = {acc, work[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    iter_s   = '0;
    if (state == MUL) begin
      acc_nxt  = acc + (work[0] ? opnd : '0);
      opnd_nxt = opnd << 1;
      work_nxt = work >> 1;
      iter_s   = acc_nxt;
    end else if (state == DIV) begin
      if (shifted >= {1'b0, opnd}) begin
        acc_nxt  = diff[WIDTH-1:0];
        work_nxt = {work[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt  = shifted[WIDTH-1:0];
        work_nxt = {work[WIDTH-2:0], 1'b0};
      end
      iter_s = neg ? -work_nxt : work_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_mul ? MUL : (go_div ? DIV : DONE);
      MUL,
      DIV:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      s       <= '0;
      ze      <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= CW'(WIDTH);
        ze      <= quick_ze;
        illegal <= quick_ill;
        if (!go_mul && !go_div) s <= quick_s;
      end else if (busy) begin
        cnt <= cnt - CW'(1);
        if (last) s <= iter_s;
      end else if (out_valid && out_ready) begin
        ze      <= 1'b0;
        illegal <= 1'b0;
      end
    end
  end

  // Operand datapath: loaded at accept, advanced once per iteration.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc  <= '0;
      work <= go_div ? a_mag : a;
      opnd <= go_div ? b_mag : b;
      neg  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (busy) begin
      acc  <= acc_nxt;
      work <= work_nxt;
      opnd <= opnd_nxt;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH = 32) with hand-computed expected values.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] instruction = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] s;
  logic        ze;
  logic        illegal;

  int checks = 0;
  int failures = 0;
  bit rdy_seen;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .instruction(instruction), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .ze(ze), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request; with hold=1 keep in_valid high with junk operands while busy.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] ins, input bit hold, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; instruction = ins; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    rdy_seen = 1'b0;
    @(negedge clk);
    if (hold) begin
      a = ~ta; b = 32'h1; instruction = 32'h0;
    end else begin
      in_valid = 1'b0;
    end
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_vld_after"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic op_check(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] ins, input logic [31:0] es, input logic eze,
                          input logic eill, input int elat);
    int lat;
    run_op(ta, tb_v, ins, 1'b0, lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_s"}, s, es);
    check({tag, "_ze"}, {31'b0, ze}, {31'b0, eze});
    check({tag, "_ill"}, {31'b0, illegal}, {31'b0, eill});
    consume(tag);
    check({tag, "_ze_clr"}, {31'b0, ze}, 32'd0);
    check({tag, "_ill_clr"}, {31'b0, illegal}, 32'd0);
  endtask

  initial begin
    int lat;
    bit stable;

    #2;
    check("rst_rdy", {31'b0, in_ready}, 32'd1);
    check("rst_vld", {31'b0, out_valid}, 32'd0);
    check("rst_s", s, 32'd0);
    check("rst_ze", {31'b0, ze}, 32'd0);
    check("rst_ill", {31'b0, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op_check("add_wrap", 32'hFFFFFFFF, 32'd2, 32'h00, 32'h00000001, 1'b0, 1'b0, 1);
    op_check("sub",      32'd5, 32'd7, 32'h01, 32'hFFFFFFFE, 1'b0, 1'b0, 1);
    op_check("lt_s",     32'hFFFFFFFF, 32'd1, 32'h14, 32'd1, 1'b0, 1'b0, 1);
    op_check("lt_u",     32'hFFFFFFFF, 32'd1, 32'h04, 32'd0, 1'b0, 1'b0, 1);
    op_check("eq",       32'h1234, 32'h1234, 32'h05, 32'd1, 1'b0, 1'b0, 1);
    op_check("gt_u",     32'd3, 32'd2, 32'h06, 32'd1, 1'b0, 1'b0, 1);
    op_check("gt_s",     32'hFFFFFFFF, 32'd2, 32'h16, 32'd0, 1'b0, 1'b0, 1);

    // Signed multiply with in_valid held high and operands changing while busy.
    run_op(32'hFFFFFFF9, 32'd6, 32'h13, 1'b1, lat);
    check("mul_s_lat", lat, 33);
    check("mul_s_s", s, 32'hFFFFFFD6);
    check("mul_s_busy_rdy", {31'b0, rdy_seen}, 32'd0);
    check("mul_s_ze", {31'b0, ze}, 32'd0);
    consume("mul_s");

    op_check("mul_u",    32'd12345, 32'd678, 32'h03, 32'd8369910, 1'b0, 1'b0, 33);
    op_check("mul_ff",   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h03, 32'h00000001, 1'b0, 1'b0, 33);
    op_check("div_min",  32'h80000000, 32'hFFFFFFFF, 32'h17, 32'h80000000, 1'b0, 1'b0, 33);
    op_check("div_u",    32'd100, 32'd7, 32'h07, 32'd14, 1'b0, 1'b0, 33);
    op_check("div_s",    32'hFFFFFFF9, 32'd2, 32'h17, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
    op_check("div_u_big", 32'hFFFFFFF9, 32'd2, 32'h07, 32'h7FFFFFFC, 1'b0, 1'b0, 33);
    op_check("div_s_pp", 32'd7, 32'hFFFFFFFE, 32'h17, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
    op_check("div_zero", 32'd5, 32'd0, 32'h07, 32'd0, 1'b1, 1'b0, 1);
    op_check("float",    32'd5, 32'd3, 32'h08, 32'd0, 1'b0, 1'b1, 1);
    op_check("op010",    32'd5, 32'd3, 32'h02, 32'd0, 1'b0, 1'b1, 1);

    // Backpressure: result must stay put for 10 cycles with out_ready low.
    run_op(32'd2, 32'd3, 32'h00, 1'b0, lat);
    check("bp_lat", lat, 1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (s !== 32'd5 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    check("bp_stable", {31'b0, stable}, 32'd1);
    check("bp_s", s, 32'd5);
    consume("bp");
    check("bp_s_hold", s, 32'd5);

    // Reset in the middle of a divide, after 10 iterations.
    @(negedge clk);
    a = 32'd1000; b = 32'd3; instruction = 32'h07; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_rdy", {31'b0, in_ready}, 32'd1);
    check("mrst_vld", {31'b0, out_valid}, 32'd0);
    check("mrst_s", s, 32'd0);
    check("mrst_ze", {31'b0, ze}, 32'd0);
    check("mrst_ill", {31'b0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_no_vld", {31'b0, out_valid}, 32'd0);
    op_check("post_rst_add", 32'd10, 32'd20, 32'h00, 32'd30, 1'b0, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
